// File: rtl/q_sys_pll_lock_supervisor_pkg.sv
// Shared types and helpers for the q_sys PLL lock supervisor.
// Holds the supervisor state encoding and a constant-width helper.
package q_sys_pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RST,
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_e;

  // Bits needed to hold values 0..value-1; used with (limit+1) for counter widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/q_sys_pll_lock_supervisor_if.sv
// PLL-side and reset-bridge-side signals of the lock supervisor.
// master = supervisor, slave = PLLs / downstream reset consumers.
interface q_sys_pll_lock_supervisor_if #(
  parameter int unsigned N_PLL = 2,
  parameter int unsigned N_RST = 4,
  parameter int unsigned CNT_W = 8
);
  logic [N_PLL-1:0] pll_locked;
  logic [N_PLL-1:0] pll_rst;
  logic [N_RST-1:0] rst_out;
  logic             all_locked;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic             timeout_err;

  modport master (
    input  pll_locked,
    output pll_rst,
    output rst_out,
    output all_locked,
    output lock_loss_cnt,
    output timeout_err
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  rst_out,
    input  all_locked,
    input  lock_loss_cnt,
    input  timeout_err
  );
endinterface

// File: rtl/q_sys_pll_lock_supervisor_bit_sync.sv
// Multi-flop synchroniser for a bus of independent asynchronous flags.
// Every stage clears on the synchronous reset.
module q_sys_bit_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/q_sys_pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL resets, qualifies lock with a stability window
// and timeout/retry, then releases downstream resets in order; recovers on lock loss.
module q_sys_pll_lock_supervisor
  import q_sys_pll_sup_pkg::*;
#(
  parameter int unsigned N_PLL          = 2,
  parameter int unsigned N_RST          = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STAGE_DELAY    = 256,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                        refclk,
  input  logic                        rst,
  q_sys_pll_lock_supervisor_if.master bus
);
  localparam int unsigned RST_CNT_W = clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned STB_CNT_W = clog2(LOCK_STABLE + 1);
  localparam int unsigned TO_CNT_W  = clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STG_CNT_W = clog2(STAGE_DELAY + 1);

  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [STB_CNT_W-1:0] STB_LAST = STB_CNT_W'(LOCK_STABLE - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STG_CNT_W-1:0] STG_LAST = STG_CNT_W'(STAGE_DELAY - 1);

  state_e               state_q, state_d;
  logic                 pll_rst_q, pll_rst_d;
  logic [N_RST-1:0]     rst_out_q, rst_out_d;
  logic [N_RST-1:0]     rst_out_shift;
  logic                 all_locked_q, all_locked_d;
  logic [CNT_W-1:0]     lock_loss_cnt_q, lock_loss_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [STB_CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [STG_CNT_W-1:0] stage_cnt_q, stage_cnt_d;

  logic [N_PLL-1:0]     locked_sync;
  logic                 lk;

  q_sys_bit_sync #(
    .WIDTH (N_PLL),
    .STAGES(SYNC_STAGES)
  ) u_locked_sync (
    .clk(refclk),
    .rst(rst),
    .d  (bus.pll_locked),
    .q  (locked_sync)
  );

  assign lk = &locked_sync;

  always_comb begin
    state_d         = state_q;
    pll_rst_d       = pll_rst_q;
    rst_out_d       = rst_out_q;
    all_locked_d    = all_locked_q;
    lock_loss_cnt_d = lock_loss_cnt_q;
    timeout_err_d   = timeout_err_q;
    rst_cnt_d       = '0;
    stable_cnt_d    = '0;
    to_cnt_d        = '0;
    stage_cnt_d     = '0;
    // Releases shift a zero in from bit 0, so bits can only free up in index order.
    rst_out_shift   = rst_out_q << 1;

    unique case (state_q)
      PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        stable_cnt_d = lk ? stable_cnt_q + 1'b1 : '0;
        to_cnt_d     = to_cnt_q + 1'b1;
        // Qualification is checked first so it wins a same-cycle timeout.
        if (lk && (stable_cnt_q == STB_LAST)) begin
          state_d      = RELEASE;
          all_locked_d = 1'b1;
          stable_cnt_d = '0;
          to_cnt_d     = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d       = PLL_RST;
          pll_rst_d     = 1'b1;
          timeout_err_d = 1'b1;
          stable_cnt_d  = '0;
          to_cnt_d      = '0;
        end
      end

      RELEASE, RUN: begin
        if (!lk) begin
          state_d      = PLL_RST;
          pll_rst_d    = 1'b1;
          rst_out_d    = '1;
          all_locked_d = 1'b0;
          if (lock_loss_cnt_q != '1) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 1'b1;
          end
        end else if (state_q == RELEASE) begin
          if (stage_cnt_q == STG_LAST) begin
            rst_out_d = rst_out_shift;
            if (rst_out_shift == '0) begin
              state_d = RUN;
            end
          end else begin
            stage_cnt_d = stage_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q         <= PLL_RST;
      pll_rst_q       <= 1'b1;
      rst_out_q       <= '1;
      all_locked_q    <= 1'b0;
      lock_loss_cnt_q <= '0;
      timeout_err_q   <= 1'b0;
      rst_cnt_q       <= '0;
      stable_cnt_q    <= '0;
      to_cnt_q        <= '0;
      stage_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      pll_rst_q       <= pll_rst_d;
      rst_out_q       <= rst_out_d;
      all_locked_q    <= all_locked_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
      timeout_err_q   <= timeout_err_d;
      rst_cnt_q       <= rst_cnt_d;
      stable_cnt_q    <= stable_cnt_d;
      to_cnt_q        <= to_cnt_d;
      stage_cnt_q     <= stage_cnt_d;
    end
  end

  assign bus.pll_rst       = {N_PLL{pll_rst_q}};
  assign bus.rst_out       = rst_out_q;
  assign bus.all_locked    = all_locked_q;
  assign bus.lock_loss_cnt = lock_loss_cnt_q;
  assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_q_sys_pll_lock_supervisor.sv
// Bench for q_sys_pll_lock_supervisor: directed scenarios plus random lock traffic,
// every cycle checked against a phase/elapsed-time model of the supervisor.
module tb_q_sys_pll_lock_supervisor;
  localparam int N_PLL          = 2;
  localparam int N_RST          = 3;
  localparam int SYNC_STAGES    = 2;
  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_STABLE    = 8;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int STAGE_DELAY    = 3;
  localparam int CNT_W          = 2;
  localparam int HIST           = 1024;

  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_QUAL = 2;

  logic             refclk;
  logic             rst;
  logic [N_PLL-1:0] pll_locked;

  int vectors    = 0;
  int miscompares = 0;

  q_sys_pll_lock_supervisor_if #(.N_PLL(N_PLL), .N_RST(N_RST), .CNT_W(CNT_W)) bus ();
  assign bus.pll_locked = pll_locked;

  q_sys_pll_lock_supervisor #(
    .N_PLL         (N_PLL),
    .N_RST         (N_RST),
    .SYNC_STAGES   (SYNC_STAGES),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_STABLE   (LOCK_STABLE),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STAGE_DELAY   (STAGE_DELAY),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // Model: which phase we are in, the edge it began on, and the input history.
  int cyc     = 0;
  int mode    = M_RST;
  int t0      = 0;
  int run     = 0;
  int loss    = 0;
  int rst_cyc = 0;
  bit terr    = 1'b0;
  bit started = 1'b0;
  bit samp [HIST];

  always @(posedge refclk) begin : model
    automatic int c, m, t, r, l;
    automatic bit te, lk;
    c  = cyc + 1;
    m  = mode;
    t  = t0;
    r  = run;
    l  = loss;
    te = terr;
    // lk seen at edge c is the AND sampled SYNC_STAGES edges earlier, if after reset
    lk = (c - SYNC_STAGES > rst_cyc) ? samp[(c - SYNC_STAGES) % HIST] : 1'b0;
    samp[c % HIST] <= &pll_locked;
    if (rst) begin
      m  = M_RST; t = c; r = 0; l = 0; te = 1'b0;
      rst_cyc <= c;
      started <= 1'b1;
    end else begin
      case (m)
        M_RST: if (c - t == PLL_RST_CYCLES) begin m = M_WAIT; t = c; r = 0; end
        M_WAIT: begin
          r = lk ? r + 1 : 0;
          if (r == LOCK_STABLE) begin m = M_QUAL; t = c; end
          else if (c - t == LOCK_TIMEOUT) begin m = M_RST; t = c; te = 1'b1; end
        end
        default: if (!lk) begin
          m = M_RST; t = c;
          if (l < (1 << CNT_W) - 1) l = l + 1;
        end
      endcase
    end
    cyc  <= c;
    mode <= m;
    t0   <= t;
    run  <= r;
    loss <= l;
    terr <= te;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge refclk) begin : compare
    automatic int rel;
    automatic logic [N_RST-1:0] exp_rst;
    automatic logic [N_PLL-1:0] exp_pll;
    if (started) begin
      exp_pll = (mode == M_RST) ? {N_PLL{1'b1}} : '0;
      exp_rst = '1;
      if (mode == M_QUAL) begin
        rel = (cyc - t0) / STAGE_DELAY;
        if (rel > N_RST) rel = N_RST;
        exp_rst = exp_rst << rel;
      end
      chk("model_pll_rst",    32'(bus.pll_rst),       32'(exp_pll));
      chk("model_rst_out",    32'(bus.rst_out),       32'(exp_rst));
      chk("model_all_locked", 32'(bus.all_locked),    32'(mode == M_QUAL));
      chk("model_loss_cnt",   32'(bus.lock_loss_cnt), 32'(loss));
      chk("model_timeout",    32'(bus.timeout_err),   32'(terr));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Returns on the negedge right after the last reset edge R; wait_cyc(n) lands on R+n.
  task automatic do_reset(input logic [N_PLL-1:0] v);
    @(negedge refclk);
    rst = 1'b1;
    pll_locked = v;
    wait_cyc(3);
    rst = 1'b0;
  endtask

  initial begin : stim
    int seg;
    rst = 1'b1;
    pll_locked = '0;

    // Clean lock: pll_rst for 4 cycles, qualify after the window, staged release.
    do_reset(2'b11);
    wait_cyc(3);  chk("s1_pll_rst_hold", 32'(bus.pll_rst), 32'h3);
    wait_cyc(1);  chk("s1_pll_rst_drop", 32'(bus.pll_rst), 32'h0);
    wait_cyc(7);  chk("s1_not_yet_locked", 32'(bus.all_locked), 32'h0);
    wait_cyc(1);  chk("s1_locked", 32'(bus.all_locked), 32'h1);
                  chk("s1_rst_111", 32'(bus.rst_out), 32'h7);
    wait_cyc(3);  chk("s1_rst_110", 32'(bus.rst_out), 32'h6);
    wait_cyc(3);  chk("s1_rst_100", 32'(bus.rst_out), 32'h4);
    wait_cyc(3);  chk("s1_rst_000", 32'(bus.rst_out), 32'h0);

    // One PLL never locks: retry every 4+32 cycles, sticky timeout.
    do_reset(2'b01);
    wait_cyc(35); chk("s2_no_timeout_yet", 32'(bus.timeout_err), 32'h0);
    wait_cyc(1);  chk("s2_timeout", 32'(bus.timeout_err), 32'h1);
                  chk("s2_repulse", 32'(bus.pll_rst), 32'h3);
    wait_cyc(4);  chk("s2_repulse_end", 32'(bus.pll_rst), 32'h0);
    wait_cyc(32); chk("s2_second_pulse", 32'(bus.pll_rst), 32'h3);
                  chk("s2_rst_out_held", 32'(bus.rst_out), 32'h7);

    // Single-cycle drop in RUN.
    do_reset(2'b11);
    wait_cyc(25); pll_locked = 2'b01;
    wait_cyc(1);  pll_locked = 2'b11;
    wait_cyc(1);  chk("s3_still_run", 32'(bus.rst_out), 32'h0);
    wait_cyc(1);  chk("s3_rst_reasserted", 32'(bus.rst_out), 32'h7);
                  chk("s3_unlocked", 32'(bus.all_locked), 32'h0);
                  chk("s3_loss_cnt", 32'(bus.lock_loss_cnt), 32'h1);
                  chk("s3_pll_rst", 32'(bus.pll_rst), 32'h3);
    wait_cyc(4);  chk("s3_pll_rst_end", 32'(bus.pll_rst), 32'h0);
    wait_cyc(8);  chk("s3_relocked", 32'(bus.all_locked), 32'h1);
    wait_cyc(9);  chk("s3_rerun", 32'(bus.rst_out), 32'h0);

    // Five losses saturate the 2-bit counter.
    do_reset(2'b11);
    for (int i = 0; i < 5; i++) begin
      wait_cyc(30); pll_locked = 2'b01;
      wait_cyc(1);  pll_locked = 2'b11;
    end
    wait_cyc(3);  chk("s4_loss_saturated", 32'(bus.lock_loss_cnt), 32'h3);

    // Glitchy lock in WAIT_LOCK only restarts the window.
    do_reset(2'b00);
    for (int i = 0; i < 6; i++) begin
      pll_locked = (i % 2 == 1) ? 2'b00 : 2'b11;
      wait_cyc(5);
    end
    chk("s5_not_locked", 32'(bus.all_locked), 32'h0);
    pll_locked = 2'b11;
    wait_cyc(100);
    chk("s5_locked", 32'(bus.all_locked), 32'h1);
    chk("s5_no_loss", 32'(bus.lock_loss_cnt), 32'h0);

    // Loss during RELEASE, then rst in RUN.
    do_reset(2'b11);
    wait_cyc(15); chk("s6_rst_110", 32'(bus.rst_out), 32'h6);
                  pll_locked = 2'b10;
    wait_cyc(1);  pll_locked = 2'b11;
    wait_cyc(1);  chk("s6_hold_110", 32'(bus.rst_out), 32'h6);
    wait_cyc(1);  chk("s6_rst_111", 32'(bus.rst_out), 32'h7);
                  chk("s6_loss_cnt", 32'(bus.lock_loss_cnt), 32'h1);
    wait_cyc(40); chk("s6_run", 32'(bus.rst_out), 32'h0);
    rst = 1'b1;
    wait_cyc(1);
    chk("s6_rst_pll_rst", 32'(bus.pll_rst), 32'h3);
    chk("s6_rst_rst_out", 32'(bus.rst_out), 32'h7);
    chk("s6_rst_locked", 32'(bus.all_locked), 32'h0);
    chk("s6_rst_loss", 32'(bus.lock_loss_cnt), 32'h0);
    chk("s6_rst_timeout", 32'(bus.timeout_err), 32'h0);
    rst = 1'b0;

    // Random lock traffic with occasional resets.
    do_reset(2'b11);
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        pll_locked = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 3));
        seg = $urandom_range(1, 40);
      end
      seg--;
      rst = ($urandom_range(0, 599) == 0);
      wait_cyc(1);
    end
    rst = 1'b0;
    wait_cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
